// File: rtl/calc_input_seq_if.sv
// Signal bundle between the operand-entry sequencer and its surroundings.
// The master side is the environment: it drives the pushbutton, the switches
// and the add/sub result. The slave side is the sequencer itself: it drives
// the operands, the op select, the captured result and the FSM state.
interface calc_input_seq_if;
  logic       btn;
  logic [2:0] sw_val;
  logic       sw_op;
  logic [2:0] a;
  logic [2:0] b;
  logic       s;
  logic [3:0] c_in;
  logic [3:0] result;
  logic       result_valid;
  logic [1:0] state_o;

  modport master (
    output btn, sw_val, sw_op, c_in,
    input  a, b, s, result, result_valid, state_o
  );

  modport slave (
    input  btn, sw_val, sw_op, c_in,
    output a, b, s, result, result_valid, state_o
  );
endinterface

// File: rtl/calc_input_seq.sv
// Operand-entry sequencer for a 3-bit sign-magnitude add/sub unit.
// Conditions the raw "enter" button (synchronizer, debounce, rising-edge
// pulse), captures operand A, then operand B with the operation, registers
// the 4-bit result returned by the arithmetic unit and holds it for display.
module calc_input_seq #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  calc_input_seq_if.slave bus
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1; width keeps headroom
  // for DEBOUNCE_CYCLES itself so the compare constant always fits.
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    COMPUTE = 2'b10,
    SHOW    = 2'b11
  } state_t;

  // -0 is folded to +0 so downstream logic and the display see one zero.
  function automatic logic [2:0] norm3(input logic [2:0] v);
    return (v == 3'b100) ? 3'b000 : v;
  endfunction

  function automatic logic [3:0] norm4(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b0000 : v;
  endfunction

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic             sync1_reg;
  logic             sync2_reg;
  logic             btn_db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= bus.btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce: accept a new level only after it has disagreed with the
  // debounced level for DEBOUNCE_CYCLES consecutive cycles; the press pulse
  // is emitted on the same edge the debounced level rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db_reg <= 1'b0;
      cnt_reg    <= '0;
      press_reg  <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync2_reg == btn_db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg >= CNT_LAST) begin
        btn_db_reg <= sync2_reg;
        cnt_reg    <= '0;
        press_reg  <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Entry FSM and datapath registers
  // ---------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [2:0] a_reg, a_next;
  logic [2:0] b_reg, b_next;
  logic       s_reg, s_next;
  logic [3:0] result_reg, result_next;
  logic       valid_reg, valid_next;

  // State and datapath registers; reset aborts any entry in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= LOAD_A;
      a_reg      <= 3'b000;
      b_reg      <= 3'b000;
      s_reg      <= 1'b0;
      result_reg <= 4'b0000;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      s_reg      <= s_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
    end
  end

  // Next-state and capture decisions; everything holds unless a capture
  // edge for that register applies in the current state.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    s_next      = s_reg;
    result_next = result_reg;
    valid_next  = valid_reg;

    case (state_reg)
      LOAD_A: begin
        if (press_reg) begin
          a_next     = norm3(bus.sw_val);
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press_reg) begin
          b_next     = norm3(bus.sw_val);
          s_next     = bus.sw_op;
          state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        // a/b/s are already stable, so c_in is valid here; presses ignored.
        result_next = norm4(bus.c_in);
        valid_next  = 1'b1;
        state_next  = SHOW;
      end
      SHOW: begin
        // A press here starts the next computation with its A entry, while
        // the old result stays on display until the next COMPUTE.
        if (press_reg) begin
          a_next     = norm3(bus.sw_val);
          valid_next = 1'b0;
          state_next = LOAD_B;
        end
      end
      default: begin
        state_next = LOAD_A;
      end
    endcase
  end

  assign bus.a            = a_reg;
  assign bus.b            = b_reg;
  assign bus.s            = s_reg;
  assign bus.result       = result_reg;
  assign bus.result_valid = valid_reg;
  assign bus.state_o      = state_reg;

endmodule
